// File: rtl/quantum_period_oracle_pkg.sv
// Shared definitions for the period oracle: FSM encoding, field positions
// of the quantum_state / quantum_measurement words, and iteration cost.
package quantum_pkg;

  // MUL (1) + REDUCE (16) + TEST (1) edges per modular multiply step
  localparam int QPO_ITER_CYCLES = 18;

  localparam int QS_A_MSB = 15;
  localparam int QS_A_LSB = 8;
  localparam int QS_N_MSB = 7;
  localparam int QS_N_LSB = 0;

  localparam int QM_H_MSB = 15;
  localparam int QM_H_LSB = 8;
  localparam int QM_R_MSB = 7;
  localparam int QM_R_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_CHECK       = 4'd1,
    ST_MUL         = 4'd2,
    ST_REDUCE      = 4'd3,
    ST_TEST        = 4'd4,
    ST_HALF_MUL    = 4'd5,
    ST_HALF_REDUCE = 4'd6,
    ST_HALF_TEST   = 4'd7,
    ST_DONE        = 4'd8
  } qpo_state_e;

endpackage

// File: rtl/quantum_period_oracle_mod_reduce_seq.sv
// Sequential restoring remainder: 16-bit dividend mod 8-bit modulus, one
// dividend bit per edge. The MSB is folded in on the start edge so the
// result and the done pulse appear 15 edges later; the consumer leaves its
// wait state on the 16th edge after start.
module mod_reduce_seq
  import quantum_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  input  logic [7:0]  i_modulus,
  output logic        o_done,
  output logic [7:0]  o_remainder
);

  localparam int STEPS = QPO_ITER_CYCLES - 2;

  logic [7:0]  r_rem;
  logic [15:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  // Partial remainder stays below the modulus, so one conditional subtract
  // per shifted-in bit is enough.
  function automatic logic [7:0] f_step(input logic [7:0] rem,
                                        input logic       bit_in,
                                        input logic [7:0] m);
    logic [8:0] t;
    t = {rem, bit_in};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[7:0];
  endfunction

  // Shift-subtract engine with a single-cycle done strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= 8'h00;
      r_shift <= 16'h0000;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem   <= f_step(8'h00, i_dividend[15], i_modulus);
        r_shift <= {i_dividend[14:0], 1'b0};
        r_cnt   <= 4'(STEPS - 1);
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_rem   <= f_step(r_rem, r_shift[15], i_modulus);
        r_shift <= {r_shift[14:0], 1'b0};
        r_cnt   <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_remainder = r_rem;

endmodule

// File: rtl/quantum_period_oracle.sv
// Classical period finder: smallest r >= 1 with a^r mod N == 1, by repeated
// modular multiplication through a shared sequential reducer.
// Optional macro QPO_HALF_POWER_EN adds a second pass computing a^(r/2) mod N
// for even r, returned in measurement[15:8].
module quantum_period_oracle
  import quantum_pkg::*;
#(
  parameter int MAX_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] quantum_state,
  output logic [15:0] quantum_measurement,
  output logic        quantum_measure_valid,
  output logic        busy,
  output logic        error
);

  localparam logic [7:0] LP_MAX = 8'(MAX_PERIOD);

  qpo_state_e  r_state, w_next;
  logic [7:0]  r_a, r_n, r_x, r_k;
  logic        r_err;
  logic [15:0] r_meas;
  logic [15:0] w_p;
  logic        w_red_start, w_red_done, w_invalid, w_hit, w_tmo;
  logic [7:0]  w_rem;
`ifdef QPO_HALF_POWER_EN
  logic [7:0]  r_y, r_j, r_r;
  logic        w_half_end;
`endif

  assign w_invalid = (r_n < 8'd2) || (r_a == 8'd0) || (r_a >= r_n);
  assign w_hit     = (r_x == 8'd1);
  assign w_tmo     = (r_k == LP_MAX);
`ifdef QPO_HALF_POWER_EN
  assign w_half_end  = (r_j == {1'b0, r_r[7:1]});
  assign w_red_start = (r_state == ST_MUL) || (r_state == ST_HALF_MUL);
  assign w_p = (r_state == ST_HALF_MUL) ? ({8'h00, r_y} * {8'h00, r_a})
                                        : ({8'h00, r_x} * {8'h00, r_a});
`else
  assign w_red_start = (r_state == ST_MUL);
  assign w_p         = {8'h00, r_x} * {8'h00, r_a};
`endif

  mod_reduce_seq u_reduce (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_red_start),
    .i_dividend (w_p),
    .i_modulus  (r_n),
    .o_done     (w_red_done),
    .o_remainder(w_rem)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_invalid ? ST_DONE : ST_MUL;
      ST_MUL:    w_next = ST_REDUCE;
      ST_REDUCE: if (w_red_done) w_next = ST_TEST;
      ST_TEST: begin
        if (w_hit) begin
`ifdef QPO_HALF_POWER_EN
          w_next = r_k[0] ? ST_DONE : ST_HALF_MUL;
`else
          w_next = ST_DONE;
`endif
        end else if (w_tmo) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_MUL;
        end
      end
`ifdef QPO_HALF_POWER_EN
      ST_HALF_MUL:    w_next = ST_HALF_REDUCE;
      ST_HALF_REDUCE: if (w_red_done) w_next = ST_HALF_TEST;
      ST_HALF_TEST:   w_next = w_half_end ? ST_DONE : ST_HALF_MUL;
`endif
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration counters, result capture on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= 8'h00;
      r_n    <= 8'h00;
      r_x    <= 8'h00;
      r_k    <= 8'h00;
      r_err  <= 1'b0;
      r_meas <= 16'h0000;
`ifdef QPO_HALF_POWER_EN
      r_y    <= 8'h00;
      r_j    <= 8'h00;
      r_r    <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_a   <= quantum_state[QS_A_MSB:QS_A_LSB];
          r_n   <= quantum_state[QS_N_MSB:QS_N_LSB];
          r_err <= 1'b0;
        end
        ST_CHECK: begin
          if (w_invalid) begin
            r_err  <= 1'b1;
            r_meas <= 16'h0000;
          end else begin
            r_x <= 8'd1;
            r_k <= 8'd0;
          end
        end
        ST_MUL:    r_k <= r_k + 8'd1;
        ST_REDUCE: if (w_red_done) r_x <= w_rem;
        ST_TEST: begin
          if (w_hit) begin
`ifdef QPO_HALF_POWER_EN
            if (!r_k[0]) begin
              r_r <= r_k;
              r_y <= 8'd1;
              r_j <= 8'd0;
            end else begin
              r_meas[QM_H_MSB:QM_H_LSB] <= 8'h00;
              r_meas[QM_R_MSB:QM_R_LSB] <= r_k;
            end
`else
            r_meas[QM_H_MSB:QM_H_LSB] <= 8'h00;
            r_meas[QM_R_MSB:QM_R_LSB] <= r_k;
`endif
          end else if (w_tmo) begin
            r_err  <= 1'b1;
            r_meas <= 16'h0000;
          end
        end
`ifdef QPO_HALF_POWER_EN
        ST_HALF_MUL:    r_j <= r_j + 8'd1;
        ST_HALF_REDUCE: if (w_red_done) r_y <= w_rem;
        ST_HALF_TEST: if (w_half_end) begin
          r_meas[QM_H_MSB:QM_H_LSB] <= r_y;
          r_meas[QM_R_MSB:QM_R_LSB] <= r_r;
        end
`endif
        default: ;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    quantum_measure_valid = (r_state == ST_DONE);
    busy                  = (r_state != ST_IDLE);
    error                 = (r_state == ST_DONE) && r_err;
    quantum_measurement   = r_meas;
  end

endmodule
